// File: rtl/ah_demux_route_stage_if.sv
// Handshake bundle between a packet source, the route stage and the AH_demux.
// The stage itself uses the slave view; the source/demux side uses master.
interface ah_demux_route_stage_if #(
  parameter int DATA_W = 109,
  parameter int SEL_W  = 5,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] ing_data;
  logic              ing_valid;
  logic              ing_ready;
  logic [DATA_W-1:0] egr_data;
  logic [SEL_W-1:0]  egr_sel;
  logic              egr_valid;
  logic              egr_ready;
  logic              drop_pulse;
  logic [CNT_W-1:0]  drop_cnt;

  modport slave (
    input  ing_data, ing_valid, egr_ready,
    output ing_ready, egr_data, egr_sel, egr_valid, drop_pulse, drop_cnt
  );

  modport master (
    output ing_data, ing_valid, egr_ready,
    input  ing_ready, egr_data, egr_sel, egr_valid, drop_pulse, drop_cnt
  );
endinterface

// File: rtl/ah_demux_route_stage.sv
// Registered routing stage ahead of the AH_demux: two-entry skid buffer, destination
// extraction into a stable select, and dropping/counting of out-of-range destinations.
module ah_demux_route_stage #(
  parameter int DATA_W    = 109,
  parameter int NUM_PORTS = 24,
  parameter int SEL_W     = 5,
  parameter int SEL_LSB   = 0,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  ah_demux_route_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // One extra bit so NUM_PORTS == 2**SEL_W still compares correctly.
  localparam logic [SEL_W:0] PORT_LIMIT = (SEL_W + 1)'(NUM_PORTS);

  state_t            state;
  logic [DATA_W-1:0] main_data;
  logic [SEL_W-1:0]  main_sel;
  logic              main_valid;
  logic [DATA_W-1:0] skid_data;
  logic [SEL_W-1:0]  skid_sel;
  logic              drop_pulse_q;
  logic [CNT_W-1:0]  drop_cnt_q;

  logic [SEL_W-1:0]  dest;
  logic              dest_legal;
  logic              ready;
  logic              accept;
  logic              legal_accept;
  logic              illegal_accept;
  logic              fire;

  assign dest           = bus.ing_data[SEL_LSB +: SEL_W];
  assign dest_legal     = ({1'b0, dest} < PORT_LIMIT);
  assign ready          = (state != FULL) && !rst;
  assign accept         = bus.ing_valid && ready;
  assign legal_accept   = accept && dest_legal;
  assign illegal_accept = accept && !dest_legal;
  assign fire           = main_valid && bus.egr_ready;

  assign bus.ing_ready  = ready;
  assign bus.egr_data   = main_data;
  assign bus.egr_sel    = main_sel;
  assign bus.egr_valid  = main_valid;
  assign bus.drop_pulse = drop_pulse_q;
  assign bus.drop_cnt   = drop_cnt_q;

  // Illegal accepts complete the handshake but never touch the buffer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      main_data    <= '0;
      main_sel     <= '0;
      main_valid   <= 1'b0;
      skid_data    <= '0;
      skid_sel     <= '0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      drop_pulse_q <= illegal_accept;
      if (illegal_accept && (drop_cnt_q != {CNT_W{1'b1}}))
        drop_cnt_q <= drop_cnt_q + 1'b1;

      case (state)
        EMPTY: begin
          if (legal_accept) begin
            main_data  <= bus.ing_data;
            main_sel   <= dest;
            main_valid <= 1'b1;
            state      <= ONE;
          end
        end
        ONE: begin
          if (legal_accept && fire) begin
            main_data <= bus.ing_data;
            main_sel  <= dest;
          end else if (legal_accept) begin
            skid_data <= bus.ing_data;
            skid_sel  <= dest;
            state     <= FULL;
          end else if (fire) begin
            main_valid <= 1'b0;
            state      <= EMPTY;
          end
        end
        FULL: begin
          if (fire) begin
            main_data <= skid_data;
            main_sel  <= skid_sel;
            state     <= ONE;
          end
        end
        default: begin
          main_valid <= 1'b0;
          state      <= EMPTY;
        end
      endcase
    end
  end

endmodule
